axi_addr_xbar_1ton: RTL and testbench
=====================================

// Module: axi_addr_xbar_1toN
// PURPOSE
//  1-master -> NSLV-slave AXI4 address-decoding crossbar with a run-time-fixed address map (BASE/MASK per slave).
//  Read and write paths are independent FSMs, so a read and a write may be in flight simultaneously.
//  Supports INCR bursts via ARLEN/AWLEN/WLAST and echoes transaction IDs.
//  Unmapped accesses are absorbed internally with DECERR. Sits between the core LSU/IFU arbiter and the SRAM/UART/CLINT slaves.
// PARAMETERS
//  NSLV      3                             number of downstream slaves (1..8)
//  AW        32                            address width
//  DW        32                            data width; strobe width is DW/8
//  IDW       4                             AXI ID width
//  SLV_BASE  {32'h10010000,32'h10000000,32'h80000000}   NSLV*AW flat; slave i at [i*AW+:AW]
//  SLV_MASK  {32'hFFFFFFF8,32'hFFFFFFF0,32'hF8000000}   NSLV*AW flat; hit_i = (addr & MASK_i) == BASE_i
// PORTS
//  clk      in   1          clock
//  rst      in   1          synchronous, active-high reset
//  s_ar*    in/out          arvalid in 1, arready out 1, araddr in AW, arid in IDW, arlen in 8
//  s_r*     out/in          rvalid out 1, rready in 1, rdata out DW, rresp out 2, rid out IDW, rlast out 1
//  s_aw*    in/out          awvalid in 1, awready out 1, awaddr in AW, awid in IDW, awlen in 8
//  s_w*     in/out          wvalid in 1, wready out 1, wdata in DW, wstrb in DW/8, wlast in 1
//  s_b*     out/in          bvalid out 1, bready in 1, bresp out 2, bid out IDW
//  m_*      mirrored        same signals, directions reversed; each flattened as NSLV*width, slave i at [i*w+:w]
// BEHAVIOUR
//  Decode: lowest-index hit wins on overlapping windows; no hit -> error target ERR.
//  Combinational, same-cycle paths: m_ar*/m_aw* payload broadcast to all slaves; valid asserted only to the target slave.
//  Read FSM R_IDLE/R_DATA/R_ERR.
//   - R_IDLE: s_arready = target's m_arready (1 for ERR).
//     On AR fire latch tgt, arid, arlen; go to R_DATA (mapped) or R_ERR.
//   - R_DATA: s_r* muxed from target; m_rready = s_rready to target only.
//     R fire with rlast -> R_IDLE.
//   - R_ERR: emit arlen+1 beats, rvalid=1, rdata=0, rresp=2'b11, rid=latched arid, rlast on final beat.
//     Beat counter is 8 bit, arlen=255 -> 256 beats; last fire -> R_IDLE.
//  Write FSM W_IDLE/W_DATA/W_RESP.
//   - W_IDLE: AW fire latches tgt, awid; -> W_DATA.
//   - W_DATA: W routed to target (ERR: wready=1, data dropped).
//     W fire with wlast -> W_RESP.
//   - W_RESP: B muxed from target; ERR gives bvalid=1, bresp=2'b11, bid=latched awid.
//     B fire -> W_IDLE.
//  AW and AR never back-pressure each other. A read and a write to the same slave may overlap; slaves must tolerate this.
//  One outstanding transaction per direction; no W before AW (s_wready=0 in W_IDLE).
//  Reset: both FSMs idle; all valid/ready outputs 0 except combinational idle arready/awready; rresp/bresp/rid/bid/rdata 0; counters 0.
//  Reset mid-burst aborts without completing responses; slaves are reset by the same rst.
//  s_rresp/s_bresp from a slave pass through unmodified (SLVERR preserved).
// TESTING
//  1. Read 0x8000_0010, arlen=3, arid=5.
//     Required: 4 beats from slave0, rid=5, rlast on beat 4 only; other slaves see no arvalid.
//  2. Write 0x1000_0000 data 0x41 strb 4'b0001, awid=2.
//     Required: slave1 gets AW/W; s_bid=2, bresp=OKAY; FSM back to W_IDLE.
//  3. Read 0x2000_0000, arlen=1, arid=7.
//     Required: 2 beats rdata=0, rresp=2'b11, rid=7, rlast on beat 2; no m_arvalid asserted.
//  4. Write 0x0000_0000, awlen=2.
//     Required: 3 W beats accepted with wready=1; then bresp=2'b11; no m_wvalid asserted.
//  5. Concurrent: AR to slave0 and AW to slave2 in the same cycle.
//     Required: both fire that cycle and both complete; a stalled rready does not block B.
//  6. rst asserted during R_DATA beat 2 of 4.
//     Required: next cycle rvalid=0, FSM R_IDLE; a fresh read then completes normally.

Source files
------------

// File: rtl/axi_addr_xbar_1ton.sv
// One AXI4 master fanned out to NSLV slaves by a fixed BASE/MASK address map.
// Reads and writes run in independent FSMs, and unmapped accesses are answered locally with DECERR.
//
// state  | meaning
// R_IDLE | waiting for AR; arready follows the decoded target
// R_DATA | R channel muxed from the latched slave until rlast
// R_ERR  | local DECERR burst of arlen+1 beats
// W_IDLE | waiting for AW; wready held low
// W_DATA | W channel routed to the latched slave (or sunk) until wlast
// W_RESP | B channel from the latched slave, or a local DECERR
module axi_addr_xbar_1ton #(
  parameter int NSLV = 3,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IDW = 4,
  parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h10010000, 32'h10000000, 32'h80000000},
  parameter logic [NSLV*AW-1:0] SLV_MASK = {32'hFFFFFFF8, 32'hFFFFFFF0, 32'hF8000000}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [AW-1:0]         s_araddr,
  input  logic [IDW-1:0]        s_arid,
  input  logic [7:0]            s_arlen,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DW-1:0]         s_rdata,
  output logic [1:0]            s_rresp,
  output logic [IDW-1:0]        s_rid,
  output logic                  s_rlast,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [AW-1:0]         s_awaddr,
  input  logic [IDW-1:0]        s_awid,
  input  logic [7:0]            s_awlen,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DW-1:0]         s_wdata,
  input  logic [DW/8-1:0]       s_wstrb,
  input  logic                  s_wlast,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  output logic [IDW-1:0]        s_bid,
  output logic [NSLV-1:0]       m_arvalid,
  input  logic [NSLV-1:0]       m_arready,
  output logic [NSLV*AW-1:0]    m_araddr,
  output logic [NSLV*IDW-1:0]   m_arid,
  output logic [NSLV*8-1:0]     m_arlen,
  input  logic [NSLV-1:0]       m_rvalid,
  output logic [NSLV-1:0]       m_rready,
  input  logic [NSLV*DW-1:0]    m_rdata,
  input  logic [NSLV*2-1:0]     m_rresp,
  input  logic [NSLV*IDW-1:0]   m_rid,
  input  logic [NSLV-1:0]       m_rlast,
  output logic [NSLV-1:0]       m_awvalid,
  input  logic [NSLV-1:0]       m_awready,
  output logic [NSLV*AW-1:0]    m_awaddr,
  output logic [NSLV*IDW-1:0]   m_awid,
  output logic [NSLV*8-1:0]     m_awlen,
  output logic [NSLV-1:0]       m_wvalid,
  input  logic [NSLV-1:0]       m_wready,
  output logic [NSLV*DW-1:0]    m_wdata,
  output logic [NSLV*DW/8-1:0]  m_wstrb,
  output logic [NSLV-1:0]       m_wlast,
  input  logic [NSLV-1:0]       m_bvalid,
  output logic [NSLV-1:0]       m_bready,
  input  logic [NSLV*2-1:0]     m_bresp,
  input  logic [NSLV*IDW-1:0]   m_bid
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_DATA = 2'd1;
  localparam logic [1:0] R_ERR  = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [1:0]     rd_state_q, rd_state_d;
  logic [SW-1:0]  rd_tgt_q, rd_tgt_d;
  logic [IDW-1:0] rd_id_q, rd_id_d;
  logic [7:0]     rd_cnt_q, rd_cnt_d;
  logic [1:0]     wr_state_q, wr_state_d;
  logic [SW-1:0]  wr_tgt_q, wr_tgt_d;
  logic [IDW-1:0] wr_id_q, wr_id_d;
  logic           wr_err_q, wr_err_d;

  logic           ar_hit, aw_hit;
  logic [SW-1:0]  ar_idx, aw_idx;

  assign m_araddr = {NSLV{s_araddr}};
  assign m_arid   = {NSLV{s_arid}};
  assign m_arlen  = {NSLV{s_arlen}};
  assign m_awaddr = {NSLV{s_awaddr}};
  assign m_awid   = {NSLV{s_awid}};
  assign m_awlen  = {NSLV{s_awlen}};
  assign m_wdata  = {NSLV{s_wdata}};
  assign m_wstrb  = {NSLV{s_wstrb}};
  assign m_wlast  = {NSLV{s_wlast}};

  // Scanning from the top down lets the lowest-index hit overwrite the others.
  always_comb begin
    ar_hit = 1'b0;
    ar_idx = '0;
    aw_hit = 1'b0;
    aw_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((s_araddr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        ar_hit = 1'b1;
        ar_idx = SW'(i);
      end
      if ((s_awaddr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        aw_hit = 1'b1;
        aw_idx = SW'(i);
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_tgt_d   = rd_tgt_q;
    rd_id_d    = rd_id_q;
    rd_cnt_d   = rd_cnt_q;
    s_arready  = 1'b0;
    m_arvalid  = '0;
    m_rready   = '0;
    s_rvalid   = 1'b0;
    s_rdata    = '0;
    s_rresp    = 2'b00;
    s_rid      = '0;
    s_rlast    = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        s_arready = 1'b1;
        for (int i = 0; i < NSLV; i++) begin
          if (ar_hit && ar_idx == SW'(i)) begin
            s_arready    = m_arready[i];
            m_arvalid[i] = s_arvalid;
          end
        end
        if (s_arvalid && s_arready) begin
          rd_tgt_d   = ar_idx;
          rd_id_d    = s_arid;
          rd_cnt_d   = s_arlen;
          rd_state_d = ar_hit ? R_DATA : R_ERR;
        end
      end
      R_DATA: begin
        for (int i = 0; i < NSLV; i++) begin
          if (rd_tgt_q == SW'(i)) begin
            s_rvalid    = m_rvalid[i];
            s_rdata     = m_rdata[i*DW +: DW];
            s_rresp     = m_rresp[i*2 +: 2];
            s_rid       = m_rid[i*IDW +: IDW];
            s_rlast     = m_rlast[i];
            m_rready[i] = s_rready;
          end
        end
        if (s_rvalid && s_rready && s_rlast) rd_state_d = R_IDLE;
      end
      R_ERR: begin
        // Down-counter loaded with arlen; terminal count 0 marks the final beat.
        s_rvalid = 1'b1;
        s_rresp  = 2'b11;
        s_rid    = rd_id_q;
        s_rlast  = (rd_cnt_q == 8'd0);
        if (s_rready) begin
          if (rd_cnt_q == 8'd0) rd_state_d = R_IDLE;
          else                  rd_cnt_d   = rd_cnt_q - 8'd1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_tgt_d   = wr_tgt_q;
    wr_id_d    = wr_id_q;
    wr_err_d   = wr_err_q;
    s_awready  = 1'b0;
    m_awvalid  = '0;
    m_wvalid   = '0;
    m_bready   = '0;
    s_wready   = 1'b0;
    s_bvalid   = 1'b0;
    s_bresp    = 2'b00;
    s_bid      = '0;
    case (wr_state_q)
      W_IDLE: begin
        s_awready = 1'b1;
        for (int i = 0; i < NSLV; i++) begin
          if (aw_hit && aw_idx == SW'(i)) begin
            s_awready    = m_awready[i];
            m_awvalid[i] = s_awvalid;
          end
        end
        if (s_awvalid && s_awready) begin
          wr_tgt_d   = aw_idx;
          wr_id_d    = s_awid;
          wr_err_d   = ~aw_hit;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wr_err_q) begin
          s_wready = 1'b1;
        end else begin
          for (int i = 0; i < NSLV; i++) begin
            if (wr_tgt_q == SW'(i)) begin
              s_wready    = m_wready[i];
              m_wvalid[i] = s_wvalid;
            end
          end
        end
        if (s_wvalid && s_wready && s_wlast) wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (wr_err_q) begin
          s_bvalid = 1'b1;
          s_bresp  = 2'b11;
          s_bid    = wr_id_q;
        end else begin
          for (int i = 0; i < NSLV; i++) begin
            if (wr_tgt_q == SW'(i)) begin
              s_bvalid    = m_bvalid[i];
              s_bresp     = m_bresp[i*2 +: 2];
              s_bid       = m_bid[i*IDW +: IDW];
              m_bready[i] = s_bready;
            end
          end
        end
        if (s_bvalid && s_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rd_tgt_q   <= '0;
      rd_id_q    <= '0;
      rd_cnt_q   <= '0;
      wr_state_q <= W_IDLE;
      wr_tgt_q   <= '0;
      wr_id_q    <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_tgt_q   <= rd_tgt_d;
      rd_id_q    <= rd_id_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_state_q <= wr_state_d;
      wr_tgt_q   <= wr_tgt_d;
      wr_id_q    <= wr_id_d;
      wr_err_q   <= wr_err_d;
    end
  end

endmodule

// File: tb/tb_axi_addr_xbar_1ton.sv
// Directed bench for axi_addr_xbar_1ton: decode vector table plus hand-written burst sequences.
// Three simple behavioural slaves answer reads with 0xD0SS00CC (slave SS, beat CC) and accept writes.
module tb_axi_addr_xbar_1ton;
  localparam int NSLV = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IDW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic [IDW-1:0] s_arid, s_rid, s_awid, s_bid;
  logic [7:0] s_arlen, s_awlen;
  logic [DW-1:0] s_rdata, s_wdata;
  logic [1:0] s_rresp, s_bresp;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [DW/8-1:0] s_wstrb;

  logic [NSLV-1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [NSLV-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [NSLV*AW-1:0] m_araddr, m_awaddr;
  logic [NSLV*IDW-1:0] m_arid, m_rid, m_awid, m_bid;
  logic [NSLV*8-1:0] m_arlen, m_awlen;
  logic [NSLV*DW-1:0] m_rdata, m_wdata;
  logic [NSLV*2-1:0] m_rresp, m_bresp;
  logic [NSLV*DW/8-1:0] m_wstrb;

  axi_addr_xbar_1ton dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rid(s_rid), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rid(m_rid), .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid)
  );

  // Slave models: one outstanding read and one outstanding write each.
  logic [NSLV-1:0] ar_en, aw_en;
  logic sr_busy[NSLV];
  logic [7:0] sr_cnt[NSLV], sr_len[NSLV];
  logic [IDW-1:0] sr_id[NSLV], ws_id[NSLV];
  logic [AW-1:0] sr_addr[NSLV], ws_addr[NSLV];
  logic [1:0] ws_st[NSLV];
  logic [7:0] ws_len[NSLV];
  logic [DW-1:0] ws_data[NSLV];
  logic [DW/8-1:0] ws_strb[NSLV];
  int arv_cnt[NSLV];
  int wv_cnt[NSLV];

  initial begin
    for (int i = 0; i < NSLV; i++) begin
      arv_cnt[i] = 0;
      wv_cnt[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NSLV; i++) begin
      if (m_arvalid[i]) arv_cnt[i] <= arv_cnt[i] + 1;
      if (m_wvalid[i]) wv_cnt[i] <= wv_cnt[i] + 1;
      if (rst) begin
        sr_busy[i] <= 1'b0;
        sr_cnt[i] <= 8'd0;
        sr_len[i] <= 8'd0;
        sr_id[i] <= '0;
        ws_st[i] <= 2'd0;
        ws_id[i] <= '0;
      end else begin
        if (m_arvalid[i] && m_arready[i]) begin
          sr_busy[i] <= 1'b1;
          sr_cnt[i] <= 8'd0;
          sr_len[i] <= m_arlen[i*8 +: 8];
          sr_id[i] <= m_arid[i*IDW +: IDW];
          sr_addr[i] <= m_araddr[i*AW +: AW];
        end else if (sr_busy[i] && m_rready[i]) begin
          if (sr_cnt[i] == sr_len[i]) sr_busy[i] <= 1'b0;
          else sr_cnt[i] <= sr_cnt[i] + 8'd1;
        end
        if (ws_st[i] == 2'd0 && m_awvalid[i] && m_awready[i]) begin
          ws_st[i] <= 2'd1;
          ws_id[i] <= m_awid[i*IDW +: IDW];
          ws_addr[i] <= m_awaddr[i*AW +: AW];
          ws_len[i] <= m_awlen[i*8 +: 8];
        end else if (ws_st[i] == 2'd1 && m_wvalid[i]) begin
          ws_data[i] <= m_wdata[i*DW +: DW];
          ws_strb[i] <= m_wstrb[i*DW/8 +: DW/8];
          if (m_wlast[i]) ws_st[i] <= 2'd2;
        end else if (ws_st[i] == 2'd2 && m_bready[i]) begin
          ws_st[i] <= 2'd0;
        end
      end
    end
  end

  always_comb begin
    m_arready = '0; m_rvalid = '0; m_rlast = '0; m_rdata = '0; m_rresp = '0; m_rid = '0;
    m_awready = '0; m_wready = '0; m_bvalid = '0; m_bresp = '0; m_bid = '0;
    for (int i = 0; i < NSLV; i++) begin
      m_arready[i] = ar_en[i] & ~sr_busy[i];
      m_rvalid[i] = sr_busy[i];
      m_rlast[i] = (sr_cnt[i] == sr_len[i]);
      m_rdata[i*DW +: DW] = 32'hD000_0000 | (32'(i) << 16) | {24'h0, sr_cnt[i]};
      m_rresp[i*2 +: 2] = (i == 1) ? 2'b10 : 2'b00;
      m_rid[i*IDW +: IDW] = sr_id[i];
      m_awready[i] = aw_en[i] & (ws_st[i] == 2'd0);
      m_wready[i] = (ws_st[i] == 2'd1);
      m_bvalid[i] = (ws_st[i] == 2'd2);
      m_bresp[i*2 +: 2] = (i == 2) ? 2'b10 : 2'b00;
      m_bid[i*IDW +: IDW] = ws_id[i];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after AR fires with arvalid dropped.
  task automatic issue_ar(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    s_arvalid = 1'b1; s_araddr = addr; s_arlen = len; s_arid = id;
    #1;
    while (!s_arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("ar_fire", 64'(s_arready), 64'd1);
    @(negedge clk);
    s_arvalid = 1'b0;
  endtask

  // src 3 means the internal error responder (rdata 0).
  task automatic collect_read(input int len, input int src, input logic [3:0] id, input logic [1:0] resp);
    int beat = 0;
    int n = 0;
    logic [31:0] exp_d;
    s_rready = 1'b1;
    while (beat <= len && n < 400) begin
      #1;
      if (s_rvalid) begin
        exp_d = (src == 3) ? 32'h0 : (32'hD000_0000 | (32'(src) << 16) | 32'(beat));
        chk("rdata", 64'(s_rdata), 64'(exp_d));
        chk("rid", 64'(s_rid), 64'(id));
        chk("rresp", 64'(s_rresp), 64'(resp));
        chk("rlast", 64'(s_rlast), 64'(beat == len));
        beat++;
      end
      n++;
      @(negedge clk);
    end
    chk("r_beats", 64'(beat), 64'(len + 1));
    s_rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input logic [31:0] data, input logic [3:0] strb, input int src, input logic [1:0] resp);
    int n = 0;
    s_awvalid = 1'b1; s_awaddr = addr; s_awlen = len; s_awid = id;
    #1;
    while (!s_awready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("aw_fire", 64'(s_awready), 64'd1);
    @(negedge clk);
    s_awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      s_wvalid = 1'b1; s_wdata = data + 32'(k); s_wstrb = strb; s_wlast = (k == int'(len));
      n = 0;
      #1;
      while (!s_wready && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk("wready", 64'(s_wready), 64'd1);
      @(negedge clk);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b1;
    n = 0;
    #1;
    while (!s_bvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("bvalid", 64'(s_bvalid), 64'd1);
    chk("bresp", 64'(s_bresp), 64'(resp));
    chk("bid", 64'(s_bid), 64'(id));
    @(negedge clk);
    s_bready = 1'b0;
    #1;
    chk("w_idle_awready", 64'(s_awready), 64'd1);
    chk("w_idle_bvalid", 64'(s_bvalid), 64'd0);
    if (src < 3) begin
      chk("slv_wdata", 64'(ws_data[src]), 64'(data + 32'(len)));
      chk("slv_wstrb", 64'(ws_strb[src]), 64'(strb));
      chk("slv_awaddr", 64'(ws_addr[src]), 64'(addr));
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0] exp_sel;
    logic exp_rdy;
  } dec_vec_t;

  dec_vec_t tbl[10];
  int snap[NSLV];
  int n;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h8000_0010, 3'b001, 1'b1};
    tbl[1] = '{32'h87FF_FFFC, 3'b001, 1'b1};
    tbl[2] = '{32'h8800_0000, 3'b000, 1'b1};
    tbl[3] = '{32'h1000_0000, 3'b010, 1'b0};
    tbl[4] = '{32'h1000_000F, 3'b010, 1'b0};
    tbl[5] = '{32'h1000_0010, 3'b000, 1'b1};
    tbl[6] = '{32'h1001_0004, 3'b100, 1'b1};
    tbl[7] = '{32'h1001_0008, 3'b000, 1'b1};
    tbl[8] = '{32'h0000_0000, 3'b000, 1'b1};
    tbl[9] = '{32'h7FFF_FFFF, 3'b000, 1'b1};

    rst = 1'b1;
    ar_en = 3'b111; aw_en = 3'b111;
    s_arvalid = 0; s_araddr = 0; s_arid = 0; s_arlen = 0; s_rready = 0;
    s_awvalid = 0; s_awaddr = 0; s_awid = 0; s_awlen = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);
    chk("rst_wready", 64'(s_wready), 64'd0);
    chk("rst_rdata_rid_rresp", 64'({s_rdata, s_rid, s_rresp}), 64'd0);
    chk("rst_bid_bresp", 64'({s_bid, s_bresp}), 64'd0);
    chk("rst_arready_idle", 64'(s_arready), 64'd1);
    chk("rst_m_valids", 64'({m_arvalid, m_awvalid, m_wvalid}), 64'd0);

    // Decode table: valids raised and dropped inside one low phase, so nothing fires.
    ar_en = 3'b101; aw_en = 3'b101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_araddr = tbl[i].addr; s_awaddr = tbl[i].addr;
      s_arvalid = 1'b1; s_awvalid = 1'b1;
      #1;
      chk("dec_m_arvalid", 64'(m_arvalid), 64'(tbl[i].exp_sel));
      chk("dec_m_awvalid", 64'(m_awvalid), 64'(tbl[i].exp_sel));
      chk("dec_s_arready", 64'(s_arready), 64'(tbl[i].exp_rdy));
      chk("dec_s_awready", 64'(s_awready), 64'(tbl[i].exp_rdy));
      #1;
      s_arvalid = 1'b0; s_awvalid = 1'b0;
    end
    ar_en = 3'b111; aw_en = 3'b111;
    @(negedge clk);

    // Mapped read burst to slave0; no other slave sees arvalid.
    for (int i = 0; i < NSLV; i++) snap[i] = arv_cnt[i];
    issue_ar(32'h8000_0010, 8'd3, 4'd5);
    collect_read(3, 0, 4'd5, 2'b00);
    chk("t1_arv0", 64'(arv_cnt[0] - snap[0]), 64'd1);
    chk("t1_arv_others", 64'(arv_cnt[1] - snap[1] + arv_cnt[2] - snap[2]), 64'd0);

    // Slave SLVERR passes through unchanged.
    issue_ar(32'h1000_0004, 8'd0, 4'd1);
    collect_read(0, 1, 4'd1, 2'b10);

    do_write(32'h1000_0000, 8'd0, 4'd2, 32'h41, 4'b0001, 1, 2'b00);

    // Unmapped read: DECERR beats, no slave touched.
    for (int i = 0; i < NSLV; i++) snap[i] = arv_cnt[i];
    issue_ar(32'h2000_0000, 8'd1, 4'd7);
    collect_read(1, 3, 4'd7, 2'b11);
    chk("t3_no_arvalid", 64'(arv_cnt[0] - snap[0] + arv_cnt[1] - snap[1] + arv_cnt[2] - snap[2]), 64'd0);

    // Unmapped write: beats sunk, no slave W.
    for (int i = 0; i < NSLV; i++) snap[i] = wv_cnt[i];
    do_write(32'h0000_0000, 8'd2, 4'd3, 32'hAA00, 4'hF, 3, 2'b11);
    chk("t4_no_wvalid", 64'(wv_cnt[0] - snap[0] + wv_cnt[1] - snap[1] + wv_cnt[2] - snap[2]), 64'd0);

    // Longest error burst: 256 beats from arlen=255.
    issue_ar(32'h4000_0000, 8'd255, 4'd9);
    collect_read(255, 3, 4'd9, 2'b11);

    // Concurrent AR (slave0) and AW (slave2); R stalled while B completes.
    s_arvalid = 1'b1; s_araddr = 32'h8000_0000; s_arlen = 8'd1; s_arid = 4'd3;
    s_awvalid = 1'b1; s_awaddr = 32'h1001_0000; s_awlen = 8'd0; s_awid = 4'd9;
    s_rready = 1'b0;
    #1;
    chk("t5_both_ready", 64'({s_arready, s_awready}), 64'b11);
    chk("t5_both_mvalid", 64'({m_arvalid, m_awvalid}), 64'b001_100);
    @(negedge clk);
    s_arvalid = 1'b0; s_awvalid = 1'b0;
    s_wvalid = 1'b1; s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wlast = 1'b1;
    #1;
    chk("t5_wready", 64'(s_wready), 64'd1);
    @(negedge clk);
    s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b1;
    n = 0;
    #1;
    while (!s_bvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("t5_bvalid", 64'(s_bvalid), 64'd1);
    chk("t5_bresp", 64'(s_bresp), 64'b10);
    chk("t5_bid", 64'(s_bid), 64'd9);
    chk("t5_r_pending", 64'(s_rvalid), 64'd1);
    @(negedge clk);
    s_bready = 1'b0;
    chk("t5_slv2_wdata", 64'(ws_data[2]), 64'h1234_5678);
    collect_read(1, 0, 4'd3, 2'b00);

    // Reset on the second beat of a 4-beat read aborts the burst.
    issue_ar(32'h8000_0000, 8'd3, 4'd4);
    s_rready = 1'b1;
    #1;
    chk("t6_beat0", 64'(s_rdata), 64'hD000_0000);
    @(negedge clk);
    #1;
    chk("t6_beat1", 64'(s_rdata), 64'hD000_0001);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_rvalid_after_rst", 64'(s_rvalid), 64'd0);
    chk("t6_idle_arready", 64'(s_arready), 64'd1);
    rst = 1'b0;
    s_rready = 1'b0;
    @(negedge clk);
    issue_ar(32'h8000_0020, 8'd0, 4'd6);
    collect_read(0, 0, 4'd6, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
